// File: rtl/usb_ep_regs.sv
// USB endpoint register block: CPU-facing status/data registers for EP0 IN, EP0 OUT and EP1 IN,
// each backed by a DEPTH-byte FIFO shared with the SIE.
module usb_ep_fifo #(
   parameter int DEPTH = 8,
   parameter int CW    = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [7:0]    din,
   input  logic          pop,
   input  logic          flush,
   output logic [7:0]    head,
   output logic [CW-1:0] count
);
   logic [7:0]    mem_q [DEPTH];
   logic [CW-1:0] wr_q, wr_d, rd_q, rd_d;

   // Flush takes priority over a pop so a flushed FIFO is always empty
   // (barring a push accepted in the same cycle).
   always_comb begin
      wr_d = push ? wr_q + CW'(1) : wr_q;
      rd_d = rd_q;
      if (flush)    rd_d = wr_q;
      else if (pop) rd_d = rd_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q[CW-2:0]] <= din;
   end

   assign head  = mem_q[rd_q[CW-2:0]];
   assign count = wr_q - rd_q;
endmodule

module usb_ep_regs #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] io_addr,
   input  logic        io_wr,
   input  logic        io_rd,
   input  logic [15:0] io_wdata,
   output logic [15:0] io_rdata,
   output logic        epi0_valid,
   output logic [7:0]  epi0_data,
   input  logic        epi0_pop,
   input  logic        epi0_ack,
   input  logic        epo0_we,
   input  logic [7:0]  epo0_data,
   input  logic        epo0_done,
   output logic        epo0_nak,
   output logic        epi1_valid,
   output logic [7:0]  epi1_data,
   input  logic        epi1_pop,
   input  logic        epi1_ack
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   localparam logic [15:0] A_I0D = 16'h5000;
   localparam logic [15:0] A_I0S = 16'h5002;
   localparam logic [15:0] A_O0D = 16'h5004;
   localparam logic [15:0] A_O0S = 16'h5006;
   localparam logic [15:0] A_I1D = 16'h5008;
   localparam logic [15:0] A_I1S = 16'h500A;

   function automatic logic [15:0] stat(input logic [CW-1:0] cnt, input logic flag, input logic ovf);
      logic [15:0] s;
      s         = '0;
      s[CW-1:0] = cnt;
      s[8]      = (cnt == FULL_CNT);
      s[9]      = (cnt == '0);
      s[10]     = ovf;
      s[15]     = flag;
      return s;
   endfunction

   // IN endpoints, index 0 = EP0 IN, index 1 = EP1 IN
   logic [1:0]          wr_dat, wr_stat, sie_pop, sie_ack;
   logic [1:0]          in_push, in_pop, in_flush, in_valid, in_full, in_empty;
   logic [1:0][7:0]     in_head;
   logic [1:0][CW-1:0]  in_cnt;
   logic [1:0]          armed_q, armed_d, in_ovf_q, in_ovf_d;

   assign wr_dat  = {io_wr && io_addr == A_I1D, io_wr && io_addr == A_I0D};
   assign wr_stat = {io_wr && io_addr == A_I1S, io_wr && io_addr == A_I0S};
   assign sie_pop = {epi1_pop, epi0_pop};
   assign sie_ack = {epi1_ack, epi0_ack};

   for (genvar i = 0; i < 2; i++) begin : g_in
      usb_ep_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (in_push[i]),
         .din   (io_wdata[7:0]),
         .pop   (in_pop[i]),
         .flush (in_flush[i]),
         .head  (in_head[i]),
         .count (in_cnt[i])
      );
      assign in_full[i]  = (in_cnt[i] == FULL_CNT);
      assign in_empty[i] = (in_cnt[i] == '0);
      assign in_valid[i] = armed_q[i] & ~in_empty[i];
   end

   always_comb begin
      in_flush = '0;
      in_push  = '0;
      in_pop   = '0;
      armed_d  = armed_q;
      in_ovf_d = in_ovf_q;
      for (int i = 0; i < 2; i++) begin
         in_flush[i] = sie_ack[i] & armed_q[i];
         in_push[i]  = wr_dat[i] & ~armed_q[i] & ~in_full[i];
         in_pop[i]   = sie_pop[i] & in_valid[i] & ~in_flush[i];
         armed_d[i]  = (armed_q[i] & ~in_flush[i]) | (wr_stat[i] & io_wdata[15] & ~armed_q[i]);
         in_ovf_d[i] = (in_ovf_q[i] & ~(wr_stat[i] & io_wdata[10]))
                     | (wr_dat[i] & ~armed_q[i] & in_full[i]);
      end
   end

   // EP0 OUT
   logic          o_wr_stat, o_rd_dat, o_flush, o_push, o_pop, o_full, o_empty;
   logic [7:0]    o_head;
   logic [CW-1:0] o_cnt;
   logic          ready_q, ready_d, o_ovf_q, o_ovf_d;

   assign o_wr_stat = io_wr && io_addr == A_O0S;
   assign o_rd_dat  = io_rd && io_addr == A_O0D;

   usb_ep_fifo #(.DEPTH(DEPTH), .CW(CW)) u_out_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (o_push),
      .din   (epo0_data),
      .pop   (o_pop),
      .flush (o_flush),
      .head  (o_head),
      .count (o_cnt)
   );
   assign o_full  = (o_cnt == FULL_CNT);
   assign o_empty = (o_cnt == '0);

   always_comb begin
      o_flush = o_wr_stat & io_wdata[15];
      o_push  = epo0_we & ~ready_q & ~o_full;
      o_pop   = o_rd_dat & ready_q & ~o_empty & ~o_flush;
      ready_d = (ready_q & ~o_flush) | (epo0_done & ~ready_q);
      o_ovf_d = (o_ovf_q & ~(o_wr_stat & io_wdata[10])) | (epo0_we & ~ready_q & o_full);
   end

   // Read mux sees pre-write state, so a simultaneous status write is not visible yet.
   logic [15:0] io_rdata_q, io_rdata_d;
   always_comb begin
      io_rdata_d = io_rdata_q;
      if (io_rd) begin
         case (io_addr)
            A_I0S:   io_rdata_d = stat(in_cnt[0], armed_q[0], in_ovf_q[0]);
            A_I1S:   io_rdata_d = stat(in_cnt[1], armed_q[1], in_ovf_q[1]);
            A_O0S:   io_rdata_d = stat(o_cnt, ready_q, o_ovf_q);
            A_O0D:   io_rdata_d = (ready_q & ~o_empty) ? {8'h00, o_head} : 16'h0000;
            default: io_rdata_d = 16'h0000;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         armed_q    <= '0;
         in_ovf_q   <= '0;
         ready_q    <= 1'b0;
         o_ovf_q    <= 1'b0;
         io_rdata_q <= '0;
      end else begin
         armed_q    <= armed_d;
         in_ovf_q   <= in_ovf_d;
         ready_q    <= ready_d;
         o_ovf_q    <= o_ovf_d;
         io_rdata_q <= io_rdata_d;
      end
   end

   assign io_rdata   = io_rdata_q;
   assign epi0_valid = in_valid[0];
   assign epi1_valid = in_valid[1];
   assign epi0_data  = in_valid[0] ? in_head[0] : 8'h00;
   assign epi1_data  = in_valid[1] ? in_head[1] : 8'h00;
   assign epo0_nak   = ready_q | o_full;
endmodule
